// File: rtl/enum_range_seq.sv
// enum_range_seq
//   Burst sequencer. A seed is accepted on a valid/ready input, then four
//   beats seed+0..seed+3 are emitted, followed by two wait cycles and a
//   one-cycle done pulse. The FSM state type is declared with enum name
//   ranges, so the members BEAT0..BEAT3, WAIT2 and WAIT1 come from range
//   expansion. Those expanded names are the ones used in every case item,
//   every transition and every output decode.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. The producer holds valid and data stable until
//   that edge. Valid never depends on ready.
//
//   Optional feature (macro ENUM_RANGE_SEQ_ABORT_EN):
//     This macro adds an abort input and an aborted output. Asserting
//     abort in any BEAT or WAIT state sends the FSM to DONE on the next
//     cycle, and aborted is raised together with done. When abort and
//     out_ready are high in the same cycle, abort wins.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   start_valid  in   1       seed offered
//   start_ready  out  1       seed accepted (high only in IDLE)
//   start_data   in   DATA_W  seed value
//   out_valid    out  1       beat valid
//   out_ready    in   1       downstream accepts beat
//   out_data     out  DATA_W  beat payload (seed + beat index, wrapping)
//   out_last     out  1       final beat of burst
//   busy         out  1       state != IDLE
//   done         out  1       one-cycle pulse in DONE
//   state_o      out  3       raw state encoding
//   abort        in   1       (ABORT_EN only) abort current burst/wait
//   aborted      out  1       (ABORT_EN only) done was reached via abort
module enum_range_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] start_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef ENUM_RANGE_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [2:0]        state_o
);

  // Expands to IDLE=0, BEAT0..BEAT3=1..4, WAIT2=5, WAIT1=6, DONE=7.
  // The wait range is declared descending, so the walk runs WAIT2 then WAIT1.
  typedef enum logic [2:0] { IDLE, BEAT[4], WAIT[2:1], DONE } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] beat_off;
  logic              abort_hit;

`ifdef ENUM_RANGE_SEQ_ABORT_EN
  logic aborted_q;
  // Abort is honoured only while a burst or its wait tail is in progress.
  assign abort_hit = abort && (state_q != IDLE) && (state_q != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_valid) begin
        seed_q <= start_data;
      end
    end
  end

`ifdef ENUM_RANGE_SEQ_ABORT_EN
  // An abort always lands in DONE, so the flag is valid exactly there.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
  assign aborted = aborted_q;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = BEAT0;
      BEAT0:   if (out_ready)   state_d = BEAT1;
      BEAT1:   if (out_ready)   state_d = BEAT2;
      BEAT2:   if (out_ready)   state_d = BEAT3;
      BEAT3:   if (out_ready)   state_d = WAIT2;
      WAIT2:   state_d = WAIT1;
      WAIT1:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = DONE;
    end
  end

  // Output decode. The outputs are a function of the state alone.
  always_comb begin
    start_ready = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    beat_off    = '0;
    case (state_q)
      IDLE:  start_ready = 1'b1;
      BEAT0: begin out_valid = 1'b1; beat_off = DATA_W'(0); end
      BEAT1: begin out_valid = 1'b1; beat_off = DATA_W'(1); end
      BEAT2: begin out_valid = 1'b1; beat_off = DATA_W'(2); end
      BEAT3: begin out_valid = 1'b1; beat_off = DATA_W'(3); out_last = 1'b1; end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The sum is truncated to DATA_W bits, so the beat value wraps modulo 2**DATA_W.
  assign out_data = out_valid ? (seed_q + beat_off) : '0;
  assign busy     = (state_q != IDLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_enum_range_seq.sv
// Directed bench for enum_range_seq. The stimulus pushes the expected beats
// ({last, data}) into exp_q. A separate negedge monitor pops one entry and
// compares it on every accepted beat. The per-cycle state walk is checked
// against hand-written tables.
module tb_enum_range_seq;
  localparam int W = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] start_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [2:0] state_o;
  logic       abort_tb = 1'b0;
`ifdef ENUM_RANGE_SEQ_ABORT_EN
  logic       aborted;
`endif

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  int st_tab[12];
  bit rdy_tab[12];
  bit abt_tab[12];
  int n_tab;
  bit abort_run = 1'b0;

  enum_range_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done),
`ifdef ENUM_RANGE_SEQ_ABORT_EN
    .abort(abort_tb), .aborted(aborted),
`endif
    .state_o(state_o)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. An aborted beat is not transferred, so it is skipped.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !abort_tb) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got %0h expected none", {out_last, out_data});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("beat", {out_last, out_data}, e);
      end
    end
  end

  // The caller is in IDLE, at posedge+1. This task offers the seed, pushes
  // nbeats expected beats, then walks the state table. When hold is set,
  // start_valid stays high and start_data changes, which tests that the
  // seed is not captured a second time.
  task automatic burst(input logic [7:0] seed, input bit hold, input int nbeats);
    int st;
    logic [7:0] d;
    chk("idle_start_ready", start_ready, 1);
    start_valid = 1'b1;
    start_data  = seed;
    out_ready   = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      d = seed + 8'(k);
      exp_q.push_back({(k == 3), d});
    end
    for (int i = 0; i < n_tab; i++) begin
      tick();
      if (i == 0) begin
        if (hold) start_data = 8'h99;
        else      start_valid = 1'b0;
      end
      st = st_tab[i];
      chk("state_o", state_o, st);
      chk("busy", busy, (st != 0));
      chk("done", done, (st == 7));
      chk("start_ready", start_ready, (st == 0));
      chk("out_valid", out_valid, (st >= 1 && st <= 4));
      if (st >= 1 && st <= 4) begin
        d = seed + 8'(st - 1);
        chk("out_data", out_data, d);
        chk("out_last", out_last, (st == 4));
      end
`ifdef ENUM_RANGE_SEQ_ABORT_EN
      chk("aborted", aborted, (abort_run && st == 7));
`endif
      out_ready = rdy_tab[i];
      abort_tb  = abt_tab[i];
    end
  endtask

  initial begin
    // Test 1: reset.
    tick();
    tick();
    chk("rst_state", state_o, 0);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Test 2: seed 10 with out_ready held high. done comes 3 cycles after the last beat.
    st_tab  = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0};
    rdy_tab = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    abt_tab = '{default: 0};
    n_tab = 8;
    burst(8'h10, 1'b0, 4);

    // Test 3: seed FE with out_ready toggling, so each beat is held one cycle. Data wraps.
    st_tab  = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 6, 7, 0};
    rdy_tab = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    n_tab = 12;
    burst(8'hFE, 1'b0, 4);

    // Test 4: start_valid held through the burst. No recapture of 0x99 occurs.
    st_tab  = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0};
    rdy_tab = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    n_tab = 8;
    burst(8'h20, 1'b1, 4);

    // start_valid is still high in IDLE with 0x99, so the next seed is accepted now.
    exp_q.push_back({1'b0, 8'h99});
    exp_q.push_back({1'b0, 8'h9A});
    tick();
    start_valid = 1'b0;
    chk("t4_recap_state", state_o, 1);
    chk("t4_recap_data", out_data, 8'h99);
    tick();
    chk("t5_state_b1", state_o, 2);
    tick();
    // Test 5: reset asserted while in BEAT2.
    chk("t5_state_b2", state_o, 3);
    chk("t5_data_b2", out_data, 8'h9B);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_state", state_o, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_start_ready", start_ready, 1);
    chk("t5_rst_busy", busy, 0);
    tick();
    chk("t5_idle_stays", state_o, 0);

`ifdef ENUM_RANGE_SEQ_ABORT_EN
    // Test 6: abort with out_ready in BEAT1 goes to DONE. No BEAT2 occurs.
    st_tab  = '{1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rdy_tab = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    abt_tab = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    n_tab = 4;
    abort_run = 1'b1;
    burst(8'h40, 1'b0, 1);
    abort_run = 1'b0;
`endif

    out_ready = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
